// File: rtl/tiny8v2_if.sv
// Memory-bus bundle between the tiny8v2 core (master) and its single-port memory (slave).
`timescale 1ns/1ps
interface tiny8v2_if #(
  parameter int WIDTH = 8
);
  logic             mem_resp;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_read;
  logic             mem_write;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;

  modport master (
    input  mem_resp, mem_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output mem_resp, mem_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/tiny8v2.sv
// tiny8v2: multicycle accumulator CPU (fetch / decode / exec / halted) on a single-port
// memory bus with a read/write request held until mem_resp.
`timescale 1ns/1ps
module tiny8v2 #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  tiny8v2_if.master        bus,
  output logic             halted,
  output logic [WIDTH-1:0] pc_out
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [2:0] OP_LDA  = 3'b000;
  localparam logic [2:0] OP_STA  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_NAND = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_BRZ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [WIDTH-1:0] ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic [2:0]       opcode_s;
  logic [WIDTH-1:0] operand_s;

  assign opcode_s  = ir_q[WIDTH-1:WIDTH-3];
  assign operand_s = {3'b000, ir_q[WIDTH-4:0]};
  assign pc_out    = pc_q;

  // Bus requests and status depend only on state; reset silences them immediately.
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = pc_q;
    bus.mem_wdata = acc_q;
    halted        = 1'b0;
    if (rst) begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      halted        = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: bus.mem_read = 1'b1;
        ST_EXEC: begin
          bus.mem_addr = operand_s;
          if (opcode_s == OP_STA) begin
            bus.mem_write = 1'b1;
          end else begin
            bus.mem_read = 1'b1;
          end
        end
        ST_HALTED: halted = 1'b1;
        default:   halted = 1'b0;
      endcase
    end
  end

  // Next-state and datapath updates; every register holds unless its state advances.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ir_d    = ir_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.mem_resp) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc_q + PC_ONE;
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (opcode_s)
          OP_JMP: begin
            pc_d    = operand_s;
            state_d = ST_FETCH;
          end
          OP_BRZ: begin
            if (acc_q == ZERO) begin
              pc_d = operand_s;
            end else begin
              pc_d = pc_q;
            end
            state_d = ST_FETCH;
          end
          OP_HALT: state_d = ST_HALTED;
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        if (bus.mem_resp) begin
          case (opcode_s)
            OP_LDA:  acc_d = bus.mem_rdata;
            OP_ADD:  acc_d = acc_q + bus.mem_rdata;
            OP_SUB:  acc_d = acc_q - bus.mem_rdata;
            OP_NAND: acc_d = ~(acc_q & bus.mem_rdata);
            default: acc_d = acc_q;
          endcase
          state_d = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase
  end

  // State registers; reset wins over any mem_resp arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      acc_q   <= ZERO;
      ir_q    <= ZERO;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_tiny8v2.sv
// Self-checking bench for tiny8v2: directed programs plus random programs compared against
// an instruction-level reference interpreter with cycle accounting.
`timescale 1ns/1ps
module tb_tiny8v2;

  typedef struct {
    int         cyc;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } acc_t;

  typedef struct {
    int         cyc;
    logic       rd;
    logic       wr;
    logic       resp;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       halted, halted2;
  logic [7:0] pc_out, pc_out2;

  logic [7:0] mem  [256];
  logic [7:0] mem2 [256];
  int         wait_n = 0;
  int         wcnt = 0;
  int         cyc = 0;
  bit         force_resp = 1'b0;
  int         errors = 0;
  int         checks = 0;

  acc_t       done_q [$];
  acc_t       exp_q  [$];
  req_t       req_q  [$];
  logic [7:0] done2  [$];

  tiny8v2_if #(.WIDTH(8)) bus  ();
  tiny8v2_if #(.WIDTH(8)) bus2 ();

  tiny8v2 #(.WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .bus(bus), .halted(halted), .pc_out(pc_out)
  );

  tiny8v2 #(.WIDTH(8), .RESET_PC(8'hFF)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .halted(halted2), .pc_out(pc_out2)
  );

  always #5 clk = ~clk;

  // Memory for the main core: responds after wait_n wait cycles, decided just after negedge.
  always @(negedge clk) begin
    #1;
    if (force_resp || ((bus.mem_read || bus.mem_write) && wcnt >= wait_n)) begin
      bus.mem_resp  = 1'b1;
      bus.mem_rdata = mem[bus.mem_addr];
    end else begin
      bus.mem_resp  = 1'b0;
      bus.mem_rdata = 8'($urandom);
    end
  end

  // Cycle counter, request trace and completed-access trace of the main core.
  always @(posedge clk) begin
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
    if (bus.mem_read || bus.mem_write) begin
      req_q.push_back('{cyc, bus.mem_read, bus.mem_write, bus.mem_resp, bus.mem_addr, bus.mem_wdata});
      if (bus.mem_resp) begin
        wcnt = 0;
        done_q.push_back('{cyc, bus.mem_write, bus.mem_addr,
                           bus.mem_write ? bus.mem_wdata : bus.mem_rdata});
        if (bus.mem_write) mem[bus.mem_addr] = bus.mem_wdata;
      end else begin
        wcnt = wcnt + 1;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Zero-wait memory for the reset-vector core.
  always @(negedge clk) begin
    #1;
    bus2.mem_resp  = bus2.mem_read || bus2.mem_write;
    bus2.mem_rdata = mem2[bus2.mem_addr];
  end

  always @(posedge clk) begin
    if (!rst && bus2.mem_resp && (bus2.mem_read || bus2.mem_write)) begin
      done2.push_back(bus2.mem_addr);
      if (bus2.mem_write) mem2[bus2.mem_addr] = bus2.mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input acc_t a);
    return {a.cyc[14:0], a.wr, a.addr, a.data};
  endfunction

  // Instruction-level interpreter: each access costs 1+w cycles, decode costs 1.
  task automatic model(input logic [7:0] start, input int w, input int max_i,
                       input logic [7:0] m_in [256], output int t_end, output int t_halt);
    logic [7:0] m [256];
    logic [7:0] pc, acc, ir, opnd, d;
    int t;
    bit stop;
    m = m_in; pc = start; acc = 8'h00; t = 0; t_halt = 0; stop = 1'b0;
    for (int n = 0; n < max_i && !stop; n++) begin
      t += 1 + w;
      ir = m[pc];
      exp_q.push_back('{t, 1'b0, pc, ir});
      pc = pc + 8'd1;
      t += 1;
      opnd = {3'b000, ir[4:0]};
      case (ir[7:5])
        3'd5: pc = opnd;
        3'd6: if (acc == 8'h00) pc = opnd;
        3'd7: begin t_halt = t; stop = 1'b1; end
        3'd1: begin
          t += 1 + w;
          m[opnd] = acc;
          exp_q.push_back('{t, 1'b1, opnd, acc});
        end
        default: begin
          t += 1 + w;
          d = m[opnd];
          exp_q.push_back('{t, 1'b0, opnd, d});
          if (ir[7:5] == 3'd0)      acc = d;
          else if (ir[7:5] == 3'd2) acc = acc + d;
          else if (ir[7:5] == 3'd3) acc = acc - d;
          else                      acc = ~(acc & d);
        end
      endcase
    end
    t_end = t;
  endtask

  // Asserts reset at a negedge and holds it for two edges; request outputs must drop at once.
  task automatic begin_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_read_forced", {31'd0, bus.mem_read}, 32'd0);
    chk("rst_write_forced", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_halted_forced", {31'd0, halted}, 32'd0);
    repeat (2) @(negedge clk);
    done_q.delete(); req_q.delete(); done2.delete();
  endtask

  // Releases reset, runs the loaded program and compares the bus trace with the model.
  task automatic run_prog(input int w, input int max_i, input string tag, output int t_halt);
    logic [7:0] m [256];
    int t_end, n, viol, late;
    m = mem;
    exp_q.delete();
    model(8'h00, w, max_i, m, t_end, t_halt);
    wait_n = w;
    rst = 1'b0;
    if (t_halt > 0) begin
      repeat (t_halt - 1) @(negedge clk);
      chk({tag, " halted_early"}, {31'd0, halted}, 32'd0);
      @(negedge clk);
      chk({tag, " halted_on_time"}, {31'd0, halted}, 32'd1);
      repeat (4) @(negedge clk);
      late = 0;
      foreach (req_q[i]) if (req_q[i].cyc >= t_halt) late++;
      chk({tag, " no_req_after_halt"}, late, 32'd0);
      chk({tag, " halted_stays"}, {31'd0, halted}, 32'd1);
    end else begin
      repeat (t_end) @(negedge clk);
      chk({tag, " not_halted"}, {31'd0, halted}, 32'd0);
    end
    chk({tag, " access_count"}, done_q.size(), exp_q.size());
    n = (done_q.size() < exp_q.size()) ? done_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s access%0d", tag, i), pack(done_q[i]), pack(exp_q[i]));
    viol = 0;
    foreach (req_q[i]) begin
      if (req_q[i].rd && req_q[i].wr) viol++;
      if (i > 0 && req_q[i].cyc == req_q[i-1].cyc + 1 && !req_q[i-1].resp) begin
        if (req_q[i].rd !== req_q[i-1].rd || req_q[i].wr !== req_q[i-1].wr ||
            req_q[i].addr !== req_q[i-1].addr ||
            (req_q[i].wr && req_q[i].wdata !== req_q[i-1].wdata)) viol++;
      end
    end
    chk({tag, " req_stable"}, viol, 32'd0);
    chk({tag, " req_cycles"}, req_q.size(), done_q.size() * (w + 1));
  endtask

  initial begin
    int th, found;
    req_t r;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; mem2[i] = 8'hE0; end
    bus.mem_resp = 1'b0; bus.mem_rdata = 8'h00;
    bus2.mem_resp = 1'b0; bus2.mem_rdata = 8'h00;

    // Reset state
    begin_reset();
    chk("reset_pc", pc_out, 8'h00);
    chk("reset_pc_vector", pc_out2, 8'hFF);

    // Test 1 (zero wait) then Test 4 (3 wait states) on the same program
    for (int pass = 0; pass < 2; pass++) begin
      begin_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[0] = 8'h10; mem[1] = 8'h51; mem[2] = 8'h32; mem[3] = 8'hE0;
      mem[8'h10] = 8'h05; mem[8'h11] = 8'h07;
      run_prog(pass * 3, 10, pass ? "t4" : "t1", th);
      chk(pass ? "t4 store" : "t1 store", mem[8'h12], 8'h0C);
      chk(pass ? "t4 write_entry" : "t1 write_entry",
          done_q.size() > 5 ? {done_q[5].wr, done_q[5].addr, done_q[5].data} : 32'd0,
          {1'b1, 8'h12, 8'h0C});
    end

    // Test 2: SUB and NAND wrap
    begin_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h71; mem[2] = 8'h32; mem[3] = 8'h93; mem[4] = 8'h34; mem[5] = 8'hE0;
    mem[8'h10] = 8'h03; mem[8'h11] = 8'h05; mem[8'h13] = 8'hF0;
    run_prog(0, 10, "t2", th);
    chk("t2 sub_wrap", mem[8'h12], 8'hFE);
    chk("t2 nand", mem[8'h14], 8'h0F);

    // Test 3: BRZ taken, BRZ not taken, JMP
    begin_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hC8; mem[8] = 8'h10; mem[9] = 8'hA4; mem[4] = 8'hC8; mem[5] = 8'hBF;
    mem[8'h1F] = 8'hE0; mem[8'h10] = 8'h01;
    run_prog(0, 10, "t3", th);
    chk("t3 brz_taken", done_q.size() > 6 ? done_q[1].addr : 8'hXX, 8'h08);
    chk("t3 brz_not_taken", done_q.size() > 6 ? done_q[5].addr : 8'hXX, 8'h05);
    chk("t3 jmp", done_q.size() > 6 ? done_q[6].addr : 8'hXX, 8'h1F);

    // Test 5: reset vector 0xFF and PC wrap
    begin_reset();
    mem2[8'hFF] = 8'h10; mem2[8'h00] = 8'hE0; mem2[8'h10] = 8'h42;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5 first_fetch", done2.size() > 2 ? done2[0] : 8'hXX, 8'hFF);
    chk("t5 wrap_fetch", done2.size() > 2 ? done2[2] : 8'hXX, 8'h00);
    chk("t5 halted", {31'd0, halted2}, 32'd1);

    // Test 6: reset during the STA write-wait cycle, with a mem_resp in the reset cycle
    begin_reset();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h10; mem[1] = 8'h32; mem[2] = 8'hE0; mem[8'h10] = 8'h05; mem[8'h12] = 8'hAA;
    wait_n = 2;
    rst = 1'b0;
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (bus.mem_write === 1'b1) found = 1;
    end
    chk("t6 reached_sta", found, 32'd1);
    rst = 1'b1; force_resp = 1'b1;
    #2;
    chk("t6 write_dropped", {31'd0, bus.mem_write}, 32'd0);
    chk("t6 read_quiet", {31'd0, bus.mem_read}, 32'd0);
    @(negedge clk);
    force_resp = 1'b0;
    chk("t6 no_write", mem[8'h12], 8'hAA);
    chk("t6 pc_reset", pc_out, 8'h00);
    mem[0] = 8'h33; mem[1] = 8'hE0; mem[8'h13] = 8'h55;
    wait_n = 0;
    req_q.delete(); done_q.delete();
    rst = 1'b0;
    @(negedge clk);
    r = '{0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00};
    if (req_q.size() > 0) r = req_q[0];
    chk("t6 first_req", {r.rd, r.wr, r.addr}, {1'b1, 1'b0, 8'h00});
    repeat (2) @(negedge clk);
    chk("t6 acc_cleared", mem[8'h13], 8'h00);

    // Random programs against the interpreter
    for (int it = 0; it < 8; it++) begin
      begin_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run_prog($urandom_range(0, 2), 20, $sformatf("rnd%0d", it), th);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
